// File: rtl/sum_acc_pkg.sv
// Shared definitions for the registered signed add/sub/accumulate block:
// operation encodings and the saturation helper used by the ALU.
package sum_acc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    // Widest accumulator the saturation helper can represent.
    localparam int MAX_ACC_W = 63;

    // Clamp a sign-extended value to the signed range of 'width' bits.
    // The result stays sign-extended to 64 bits; callers truncate it.
    function automatic logic signed [63:0] sat_sext(input logic signed [63:0] value,
                                                     input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/sum_acc_alu.sv
// Combinational datapath: produces the result, overflow flag and the next
// accumulator value for one operation. Registers live in the top level.
module sum_acc_alu
    import sum_acc_pkg::*;
#(
    parameter int W     = 4,
    parameter int ACC_W = 8,
    parameter int SAT   = 0
) (
    input  logic [1:0]             op,
    input  logic signed [W-1:0]    a,
    input  logic signed [W-1:0]    b,
    input  logic signed [ACC_W-1:0] acc_q,
    output logic signed [ACC_W-1:0] x,
    output logic signed [ACC_W-1:0] acc_next,
    output logic                   ovf
);

    logic signed [ACC_W-1:0] a_ext;
    logic signed [ACC_W-1:0] b_ext;
    logic signed [ACC_W:0]   acc_sum;
    logic                    acc_sum_ovf;

    // Sign-extend operands and form the one-bit-wider accumulator sum.
    always_comb begin
        a_ext       = {{(ACC_W - W){a[W-1]}}, a};
        b_ext       = {{(ACC_W - W){b[W-1]}}, b};
        acc_sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - W){a[W-1]}}, a};
        // The sum left the ACC_W range when its top two bits disagree.
        acc_sum_ovf = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
    end

    // Select the result and accumulator update for the requested operation.
    always_comb begin
        x        = '0;
        ovf      = 1'b0;
        acc_next = acc_q;
        case (op)
            OP_ADD: x = a_ext + b_ext;
            OP_SUB: x = a_ext - b_ext;
            OP_ACC: begin
                ovf = acc_sum_ovf;
                if (SAT != 0) begin
                    x = ACC_W'(sat_sext(64'(acc_sum), ACC_W));
                end else begin
                    x = acc_sum[ACC_W-1:0];
                end
                acc_next = x;
            end
            default: begin
                // Dump-and-clear: report the old total, then zero it.
                x        = acc_q;
                acc_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/sum_acc_pipe.sv
// Registered signed add/sub/accumulate block with valid/ready on both sides
// and a single result register that holds under backpressure.
module sum_acc_pipe
    import sum_acc_pkg::*;
#(
    parameter int W     = 4,
    parameter int ACC_W = 8,
    parameter int SAT   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    input  logic [1:0]              op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] x,
    output logic                    ovf,
    output logic signed [ACC_W-1:0] acc_q
);

    // The ADD/SUB results are only exact if the result is wider than operands.
    generate
        if (ACC_W < W + 1) begin : g_bad_width
            $error("sum_acc_pipe: ACC_W must be at least W+1");
        end
        if (ACC_W > MAX_ACC_W) begin : g_too_wide
            $error("sum_acc_pipe: ACC_W exceeds saturation helper width");
        end
    endgenerate

    logic                    out_valid_reg;
    logic signed [ACC_W-1:0] x_reg;
    logic                    ovf_reg;
    logic signed [ACC_W-1:0] acc_reg;

    logic signed [ACC_W-1:0] x_next;
    logic signed [ACC_W-1:0] acc_next;
    logic                    ovf_next;
    logic                    accept;
    logic                    consume;

    sum_acc_alu #(
        .W     (W),
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_alu (
        .op       (op),
        .a        (a),
        .b        (b),
        .acc_q    (acc_reg),
        .x        (x_next),
        .acc_next (acc_next),
        .ovf      (ovf_next)
    );

    // A new input may enter whenever the result slot is empty or draining.
    always_comb begin
        in_ready = !out_valid_reg || out_ready;
        accept   = in_valid && in_ready;
        consume  = out_valid_reg && out_ready;
    end

    // Result and accumulator registers; inputs are captured only on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            x_reg         <= '0;
            ovf_reg       <= 1'b0;
            acc_reg       <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            x_reg         <= x_next;
            ovf_reg       <= ovf_next;
            acc_reg       <= acc_next;
        end else if (consume) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign x         = x_reg;
    assign ovf       = ovf_reg;
    assign acc_q     = acc_reg;

endmodule

// File: tb/tb_sum_acc_pipe.sv
// Directed bench: one 8-bit wrapping instance plus 6-bit saturating and
// 6-bit wrapping instances, all driven from the same stimulus.
module tb_sum_acc_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;

    logic       in_ready0, out_valid0, ovf0;
    logic [7:0] x0, acc0;
    logic       in_ready1, out_valid1, ovf1;
    logic [5:0] x1, acc1;
    logic       in_ready2, out_valid2, ovf2;
    logic [5:0] x2, acc2;

    int n_checks;
    int n_fail;

    sum_acc_pipe #(.W(4), .ACC_W(8), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
        .x(x0), .ovf(ovf0), .acc_q(acc0)
    );

    sum_acc_pipe #(.W(4), .ACC_W(6), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
        .x(x1), .ovf(ovf1), .acc_q(acc1)
    );

    sum_acc_pipe #(.W(4), .ACC_W(6), .SAT(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
        .x(x2), .ovf(ovf2), .acc_q(acc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b iv=%0b op=%0d a=%0d | ov0=%0b x0=%0d acc0=%0d | x1=%0d ovf1=%0b | x2=%0d ovf2=%0b",
                 $time, rst, in_valid, op, $signed(a), out_valid0, $signed(x0), $signed(acc0),
                 $signed(x1), ovf1, $signed(x2), ovf2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid0); end
        n_checks++;
        if (x0 !== 8'h00) begin n_fail++; $display("FAIL reset_x got %h want 00", x0); end
        n_checks++;
        if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf0); end
        n_checks++;
        if (acc0 !== 8'h00) begin n_fail++; $display("FAIL reset_acc got %h want 00", acc0); end
        n_checks++;
        if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready0); end
    endtask

    task automatic test_add_sub();
        do_reset();
        in_valid = 1'b1; op = 2'b00; a = 4'h8; b = 4'h8;   // -8 + -8
        step();
        n_checks++;
        if (out_valid0 !== 1'b1 || x0 !== 8'hF0 || ovf0 !== 1'b0) begin
            n_fail++; $display("FAIL add got v=%0b x=%h ovf=%0b want v=1 x=f0 ovf=0", out_valid0, x0, ovf0);
        end
        op = 2'b01; a = 4'h7; b = 4'h8;                    // 7 - (-8)
        step();
        n_checks++;
        if (x0 !== 8'h0F || ovf0 !== 1'b0) begin
            n_fail++; $display("FAIL sub got x=%h ovf=%0b want x=0f ovf=0", x0, ovf0);
        end
        n_checks++;
        if (acc0 !== 8'h00) begin n_fail++; $display("FAIL addsub_acc got %h want 00", acc0); end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid0 !== 1'b0 || x0 !== 8'h0F) begin
            n_fail++; $display("FAIL drain_hold got v=%0b x=%h want v=0 x=0f", out_valid0, x0);
        end
    endtask

    task automatic test_acc_stream();
        logic [7:0] exp_x;
        do_reset();
        in_valid = 1'b1; op = 2'b10; a = 4'h7; b = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_x = 8'(7 * k);
            n_checks++;
            if (out_valid0 !== 1'b1 || x0 !== exp_x || acc0 !== exp_x || ovf0 !== 1'b0) begin
                n_fail++;
                $display("FAIL acc_stream[%0d] got v=%0b x=%0d acc=%0d ovf=%0b want v=1 x=%0d acc=%0d ovf=0",
                         k, out_valid0, x0, acc0, ovf0, exp_x, exp_x);
            end
        end
        op = 2'b11;
        step();
        n_checks++;
        if (out_valid0 !== 1'b1 || x0 !== 8'd49 || acc0 !== 8'h00 || ovf0 !== 1'b0) begin
            n_fail++; $display("FAIL clr got v=%0b x=%0d acc=%0d ovf=%0b want v=1 x=49 acc=0 ovf=0",
                               out_valid0, x0, acc0, ovf0);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_sat_wrap();
        logic [5:0] exp_sat [5];
        logic [5:0] exp_wrap [5];
        logic       exp_ovf [5];
        exp_sat  = '{6'd7, 6'd14, 6'd21, 6'd28, 6'd31};
        exp_wrap = '{6'd7, 6'd14, 6'd21, 6'd28, 6'h23};   // 0x23 = -29
        exp_ovf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        in_valid = 1'b1; op = 2'b10; a = 4'h7; b = 4'h0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (x1 !== exp_sat[k] || ovf1 !== exp_ovf[k] || acc1 !== exp_sat[k]) begin
                n_fail++; $display("FAIL sat[%0d] got x=%0d ovf=%0b acc=%0d want x=%0d ovf=%0b",
                                   k, x1, ovf1, acc1, exp_sat[k], exp_ovf[k]);
            end
            n_checks++;
            if (x2 !== exp_wrap[k] || ovf2 !== exp_ovf[k] || acc2 !== exp_wrap[k]) begin
                n_fail++; $display("FAIL wrap[%0d] got x=%h ovf=%0b acc=%h want x=%h ovf=%0b",
                                   k, x2, ovf2, acc2, exp_wrap[k], exp_ovf[k]);
            end
        end
        a = 4'h8;                                          // -8
        step();
        n_checks++;
        if (x1 !== 6'd23 || ovf1 !== 1'b0) begin
            n_fail++; $display("FAIL sat_recover got x=%0d ovf=%0b want x=23 ovf=0", x1, ovf1);
        end
        n_checks++;
        if (x2 !== 6'd27 || ovf2 !== 1'b1) begin           // -37 wraps to 27
            n_fail++; $display("FAIL wrap_under got x=%0d ovf=%0b want x=27 ovf=1", x2, ovf2);
        end
        n_checks++;
        if (x0 !== 8'd27 || ovf0 !== 1'b0) begin           // 35 - 8 exact at 8 bits
            n_fail++; $display("FAIL wide_acc got x=%0d ovf=%0b want x=27 ovf=0", x0, ovf0);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; op = 2'b10; a = 4'h7; b = 4'h0;
        step(); step(); step();                            // acc = 21
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %0b want 0", in_ready0); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (out_valid0 !== 1'b1 || x0 !== 8'd21 || acc0 !== 8'd21 || in_ready0 !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%0b x=%0d acc=%0d rdy=%0b want v=1 x=21 acc=21 rdy=0",
                                   k, out_valid0, x0, acc0, in_ready0);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", in_ready0); end
        step();
        n_checks++;
        if (out_valid0 !== 1'b1 || x0 !== 8'd28 || acc0 !== 8'd28) begin
            n_fail++; $display("FAIL bp_release got v=%0b x=%0d acc=%0d want v=1 x=28 acc=28",
                               out_valid0, x0, acc0);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; op = 2'b10; a = 4'h7; b = 4'h0;
        step(); step(); step();
        n_checks++;
        if (acc0 !== 8'd21 || out_valid0 !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup got acc=%0d v=%0b want acc=21 v=1", acc0, out_valid0);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (out_valid0 !== 1'b0 || x0 !== 8'h00 || acc0 !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset got v=%0b x=%0d acc=%0d want v=0 x=0 acc=0",
                               out_valid0, x0, acc0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid0 !== 1'b0 || acc0 !== 8'h00) begin
            n_fail++; $display("FAIL mid_no_accept got v=%0b acc=%0d want v=0 acc=0", out_valid0, acc0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 4'h0;
        b         = 4'h0;
        op        = 2'b00;
        test_reset();
        test_add_sub();
        test_acc_stream();
        test_sat_wrap();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_acc_pipe.md
Name: sum_acc_pipe

Overview:
- Parametrised, registered successor to the combinational signed adder. Performs signed add, subtract, accumulate and dump-and-clear on W-bit two's-complement operands.
- Valid/ready on input and output; one registered result stage with backpressure.
- Used wherever signed sums must be pipelined, accumulated or throttled by a downstream consumer.

Parameters:
- W, 4: operand width, signed.
- ACC_W, 8: accumulator and result width; must satisfy ACC_W >= W+1, enforced by elaboration-time check.
- SAT, 0: 0 = accumulator wraps modulo 2^ACC_W; 1 = accumulator saturates to min/max.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept this cycle
- a  in  W  signed operand A
- b  in  W  signed operand B (ignored for ACC/CLR)
- op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- out_valid  out  1  result held in x
- out_ready  in  1  consumer accepts x
- x  out  ACC_W  signed result
- ovf  out  1  ACC overflow/saturation occurred on this result
- acc_q  out  ACC_W  current accumulator value (observation)

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, x=0, ovf=0, acc_q=0. Reset overrides any transfer in the same cycle; a pending unconsumed result is discarded.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready. Output consumed = out_valid && out_ready.
- On accept, the result is registered and out_valid=1 on the next edge. Latency is 1 cycle; throughput is 1 per cycle when out_ready=1.
- On consume without accept: out_valid=0. x and ovf hold their last values.
- While out_valid && !out_ready: x, ovf and out_valid hold. in_ready=0 and no state changes.
- ADD: x = sext(a)+sext(b) at ACC_W. Result is exact (W+1 <= ACC_W). ovf=0. Accumulator unchanged.
- SUB: x = sext(a)-sext(b), exact. ovf=0. Accumulator unchanged.
- ACC:
  - s = acc_q + sext(a), computed at ACC_W+1 bits.
  - If s is outside the ACC_W range: ovf=1. With SAT=1, acc_q and x take the max or min limit. With SAT=0, acc_q and x take the low ACC_W bits of s (wrap).
  - Otherwise acc_q = x = s and ovf=0.
- CLR: x = acc_q as it was before the clear, ovf=0, acc_q=0. This is the dump-and-clear operation.
- Back-to-back ACC accepts see the updated acc_q with no bubble; the accumulator is a single register updated on accept.
- Simultaneous consume and accept: the new result replaces the old one and out_valid stays 1.
- No X propagation: a, b and op are sampled only on accept.

Decomposition:
- Package sum_acc_pkg holds:
  - op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_ACC=2'b10, OP_CLR=2'b11;
  - function sat_sext(value, width) for saturation limits.
- One sub-module, sum_acc_alu: purely combinational. Computes the result and ovf from a, b, op and acc_q, for the chosen SAT mode.
- The top level holds the handshake and registers.

Test Plan:
- W=4, ACC_W=8, out_ready=1: ADD a=-8, b=-8 -> one cycle later out_valid=1, x=8'hF0 (-16), ovf=0. SUB a=7, b=-8 -> x=15.
- ACC stream: a=7 accepted on 7 consecutive cycles, then CLR -> x sequence 7,14,21,28,35,42,49, then 49; acc_q=0 after CLR; no bubbles.
- ACC_W=6, SAT=1: ACC a=7 five times -> x = 7,14,21,28, then 31 with ovf=1. Next ACC a=-8 -> x=23, ovf=0.
- ACC_W=6, SAT=0: same stimulus -> fifth result x=-29 (35 wrapped), ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, x and out_valid stable, acc_q unchanged. Raise out_ready -> the pending input is accepted in the same cycle and out_valid stays 1.
- Reset mid-operation: after acc_q=21 with out_valid=1, assert rst for 1 cycle while in_valid=1 -> out_valid=0, x=0, acc_q=0. The input in that cycle is not accepted.
